// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: after init, grants the bus to refresh, write or read stages
// and muxes the granted stage's command, bank and address onto the SDRAM pins.
module sdram_arbit #(
  parameter logic [3:0] NOP_CMD = 4'b0111
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  // init stage
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic        init_end,
  // auto-refresh stage
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  // write stage
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,
  // read stage
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  // grants
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  // SDRAM pins
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  inout  wire  [15:0] sdram_dq
);

  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] ARBIT = 3'd1;
  localparam logic [2:0] AREF  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] READ  = 3'd4;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  logic [2:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       pick_wr, pick_rd;
  logic [3:0] cmd;

  // On a wr/rd tie the stage not served last wins.
  assign pick_wr = wr_req && (!rd_req || (last_grant_q == GRANT_RD));
  assign pick_rd = rd_req && (!wr_req || (last_grant_q == GRANT_WR));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      INIT:  if (init_end) state_d = ARBIT;
      ARBIT: begin
        if (aref_req) begin
          state_d = AREF;
        end else if (pick_wr) begin
          state_d      = WRITE;
          last_grant_d = GRANT_WR;
        end else if (pick_rd) begin
          state_d      = READ;
          last_grant_d = GRANT_RD;
        end
      end
      AREF:  if (aref_end) state_d = ARBIT;
      WRITE: if (wr_end)   state_d = ARBIT;
      READ:  if (rd_end)   state_d = ARBIT;
      default: state_d = ARBIT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= INIT;
      last_grant_q <= GRANT_RD;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign aref_en = (state_q == AREF);
  assign wr_en   = (state_q == WRITE);
  assign rd_en   = (state_q == READ);

  // Unowned or unknown encodings present NOP with all-ones bank/address.
  always_comb begin
    cmd        = NOP_CMD;
    sdram_ba   = 2'b11;
    sdram_addr = 13'h1fff;
    case (state_q)
      INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;
  assign sdram_dq  = (wr_en && wr_sdram_en) ? wr_sdram_data : 16'bz;

endmodule

// File: tb/tb_sdram_arbit.sv
// Table-driven bench for sdram_arbit: per-cycle vectors plus hand-written reset sequences.
module tb_sdram_arbit;

  localparam logic [2:0] SI = 3'd0, SA = 3'd1, SR = 3'd2, SW = 3'd3, SD = 3'd4;
  localparam logic [15:0] TB_DQ = 16'h3C3C;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end = 1'b0, aref_req = 1'b0, aref_end = 1'b0;
  logic        wr_req = 1'b0, wr_end = 1'b0, rd_req = 1'b0, rd_end = 1'b0;
  logic        wr_sdram_en = 1'b0, tb_drive = 1'b0;
  logic [15:0] wr_sdram_data = 16'h0000;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  wire  [15:0] sdram_dq;

  // Bench-side driver reveals whether the DUT releases the bus.
  assign sdram_dq = tb_drive ? TB_DQ : 16'hzzzz;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_cmd(4'h1), .init_ba(2'd0), .init_addr(13'h0101), .init_end(init_end),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(4'h2), .aref_ba(2'd1), .aref_addr(13'h0202),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(4'h4), .wr_ba(2'd2), .wr_addr(13'h0404),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(4'h5), .rd_ba(2'd3), .rd_addr(13'h0505),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
  );

  typedef struct {
    logic        rst_n, ie, ar, ae, wq, we, rq, re, wen, drv;
    logic [15:0] wdata;
    logic [2:0]  st;
    logic        chk_dq;
    logic [15:0] dq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst_n, ie, ar, ae, wq, we, rq, re, wen, drv,
                             input logic [15:0] wdata, input logic [2:0] st,
                             input logic chk_dq, input logic [15:0] dq);
    vec_t r;
    r.rst_n = rst_n; r.ie = ie; r.ar = ar; r.ae = ae; r.wq = wq; r.we = we;
    r.rq = rq; r.re = re; r.wen = wen; r.drv = drv; r.wdata = wdata;
    r.st = st; r.chk_dq = chk_dq; r.dq = dq;
    return r;
  endfunction

  // Expected {cmd, ba, addr} for a given owner.
  function automatic logic [18:0] exp_bus(input logic [2:0] st);
    case (st)
      SI:      return {4'h1, 2'd0, 13'h0101};
      SR:      return {4'h2, 2'd1, 13'h0202};
      SW:      return {4'h4, 2'd2, 13'h0404};
      SD:      return {4'h5, 2'd3, 13'h0505};
      default: return {4'b0111, 2'b11, 13'h1fff};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] st);
    check({name, " grants"}, {29'd0, aref_en, wr_en, rd_en},
          {29'd0, st == SR, st == SW, st == SD});
    check({name, " bus"},
          {13'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
          {13'd0, exp_bus(st)});
    check({name, " cke"}, {31'd0, sdram_cke}, 32'd1);
  endtask

  initial begin
    //            rst ie ar ae wq we rq re wen drv wdata     st  chk dq
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, SI, 1, TB_DQ));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, SI, 0, 16'h0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, SI, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, SA, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, SA, 0, 16'h0));
    // all three request: refresh first, then write wins the first tie
    vecs.push_back(v(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 16'h0000, SR, 0, 16'h0));
    vecs.push_back(v(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 16'h0000, SR, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 16'h0000, SA, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000, SW, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 16'hA5A5, SW, 1, 16'hA5A5));
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 16'hA5A5, SW, 1, TB_DQ));
    vecs.push_back(v(1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 16'h0000, SA, 0, 16'h0));
    // fairness: alternating grants with an ARBIT gap
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000, SD, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 16'h0000, SA, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000, SW, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 16'h0000, SA, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000, SD, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 16'h0000, SA, 0, 16'h0));
    // refresh request mid-write waits, then beats the pending read
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, SW, 0, 16'h0));
    vecs.push_back(v(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0000, SW, 0, 16'h0));
    vecs.push_back(v(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 16'h0000, SA, 0, 16'h0));
    vecs.push_back(v(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0000, SR, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 16'h0000, SA, 0, 16'h0));
    // refresh did not touch last_grant (WRITE), so the tie goes to read
    vecs.push_back(v(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000, SD, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 16'h1234, SD, 1, TB_DQ));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, SA, 0, 16'h0));
    // stray end pulses in ARBIT
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, SA, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0000, SA, 0, 16'h0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, SD, 0, 16'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge sys_clk);
      sys_rst_n = vecs[i].rst_n; init_end = vecs[i].ie;
      aref_req = vecs[i].ar; aref_end = vecs[i].ae;
      wr_req = vecs[i].wq; wr_end = vecs[i].we;
      rd_req = vecs[i].rq; rd_end = vecs[i].re;
      wr_sdram_en = vecs[i].wen; tb_drive = vecs[i].drv; wr_sdram_data = vecs[i].wdata;
      @(posedge sys_clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].st);
      if (vecs[i].chk_dq) check($sformatf("vec%0d dq", i), {16'd0, sdram_dq}, {16'd0, vecs[i].dq});
    end

    // Reset mid-READ: grant drops without waiting for a clock edge.
    @(negedge sys_clk);
    rd_req = 1'b0; init_end = 1'b0; wr_sdram_en = 1'b1; wr_sdram_data = 16'hFFFF;
    tb_drive = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    check_state("rst_mid_read", SI);
    check("rst_mid_read dq", {16'd0, sdram_dq}, {16'd0, TB_DQ});
    @(negedge sys_clk);
    rd_end = 1'b1;
    @(posedge sys_clk); #1;
    check_state("rst_held", SI);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check_state("stray_rd_end_init", SI);
    @(negedge sys_clk);
    init_end = 1'b1;
    @(posedge sys_clk); #1;
    check_state("reinit_arbit", SA);

    // Reset mid-WRITE with the data bus driven.
    @(negedge sys_clk);
    rd_end = 1'b0; wr_req = 1'b1; tb_drive = 1'b0; wr_sdram_data = 16'hBEEF;
    @(posedge sys_clk); #1;
    check_state("write_again", SW);
    check("write_again dq", {16'd0, sdram_dq}, {16'd0, 16'hBEEF});
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0; tb_drive = 1'b1;
    #1;
    check_state("rst_mid_write", SI);
    check("rst_mid_write dq", {16'd0, sdram_dq}, {16'd0, TB_DQ});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
